keypad_scan: RTL and testbench

//  Upstream stage of the game-state block. Scans the 4x3 board keypad, debounces it and issues one
//  key_valid pulse per accepted press, with the key code on key_data (1..9 select board cells).

---
 rtl/keypad_pkg.sv | 58 +++++
 rtl/keypad_scan_if.sv | 22 ++
 rtl/tick_gen.sv | 30 +++
 rtl/keypad_scan.sv | 152 +++++++++++++++
 tb/tb_keypad_scan.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, special key codes, debounce states
// and the combinational frame decoder used by keypad_scan.
package keypad_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 3;
    localparam int FRAME_BITS = NUM_ROWS * NUM_COLS;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_ZERO = 4'hB;
    localparam logic [3:0] KEY_HASH = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } kp_state_t;

    typedef enum logic [1:0] {
        FRAME_NONE,
        FRAME_ONE,
        FRAME_MULTI
    } frame_kind_t;

    typedef struct packed {
        frame_kind_t kind;
        logic [3:0]  code;
    } frame_result_t;

    // Frame bit r*NUM_COLS+c holds row r as seen while column c was driven.
    function automatic frame_result_t decode_frame(input logic [FRAME_BITS-1:0] frame);
        frame_result_t res;
        int unsigned   ones;
        res.kind = FRAME_NONE;
        res.code = '0;
        ones     = 0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (frame[r*NUM_COLS + c]) begin
                    ones++;
                    if (r == NUM_ROWS - 1) begin
                        res.code = (c == 0) ? KEY_STAR : (c == 1) ? KEY_ZERO : KEY_HASH;
                    end else begin
                        res.code = 4'(3*r + c + 1);
                    end
                end
            end
        end
        if (ones == 1) begin
            res.kind = FRAME_ONE;
        end else if (ones > 1) begin
            res.kind = FRAME_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the key report towards the game-state block.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic                key_en;
    logic [NUM_ROWS-1:0] key_row;
    logic [NUM_COLS-1:0] key_col;
    logic [3:0]          key_data;
    logic                key_valid;
    logic                key_down;

    modport master (
        input  key_en, key_row,
        output key_col, key_data, key_valid, key_down
    );

    modport slave (
        output key_en, key_row,
        input  key_col, key_data, key_valid, key_down
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for one clk every DIV clks (when count is DIV-1).
module tick_gen #(
    parameter int DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner: column drive, per-frame row sampling, frame decode and
// a press/release debounce FSM that emits one key_valid pulse per accepted press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 25000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);

    localparam int               CNT_W      = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]       LAST_COL   = 2'(NUM_COLS - 1);

    logic tick;

    tick_gen #(.DIV(SCAN_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic [1:0]            col_idx_reg, col_idx_next;
    logic [FRAME_BITS-1:0] frame_reg, frame_next, frame_base;
    logic                  frame_done_reg;
    logic                  frame_end;

    assign frame_end    = tick && (col_idx_reg == LAST_COL);
    assign col_idx_next = !tick ? col_idx_reg :
                          (col_idx_reg == LAST_COL) ? 2'd0 : col_idx_reg + 2'd1;

    // The completed frame is consumed one clk after frame_end, then cleared.
    assign frame_base = frame_done_reg ? '0 : frame_reg;

    for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_slot
        localparam int ROW = gi / NUM_COLS;
        localparam int COL = gi % NUM_COLS;
        assign frame_next[gi] = (tick && col_idx_reg == 2'(COL)) ? kp.key_row[ROW]
                                                                 : frame_base[gi];
    end

    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        assign kp.key_col[gi] = (col_idx_reg == 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx_reg    <= '0;
            frame_reg      <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            col_idx_reg    <= col_idx_next;
            frame_reg      <= frame_next;
            frame_done_reg <= frame_end;
        end
    end

    kp_state_t        state_reg, state_next;
    logic [3:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [3:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             down_reg, down_next;
    frame_result_t    frame_res;

    assign frame_res = decode_frame(frame_reg);
    assign cnt_inc   = (cnt_reg == CNT_ACCEPT) ? cnt_reg : cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        down_next  = down_reg;
        if (frame_done_reg) begin
            case (state_reg)
                IDLE: begin
                    if (frame_res.kind == FRAME_ONE) begin
                        cand_next  = frame_res.code;
                        cnt_next   = CNT_ONE;
                        state_next = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (frame_res.kind == FRAME_ONE && frame_res.code == cand_reg) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_ACCEPT) begin
                            // Accepted with key_en low: consumed silently, never replayed.
                            state_next = HELD;
                            down_next  = 1'b1;
                            valid_next = kp.key_en;
                            if (kp.key_en) begin
                                data_next = cand_reg;
                            end
                        end
                    end else if (frame_res.kind == FRAME_ONE) begin
                        cand_next = frame_res.code;
                        cnt_next  = CNT_ONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
                HELD: begin
                    if (frame_res.kind == FRAME_NONE) begin
                        cnt_next   = CNT_ONE;
                        state_next = RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (frame_res.kind == FRAME_NONE) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_ACCEPT) begin
                            state_next = IDLE;
                            down_next  = 1'b0;
                        end
                    end else begin
                        state_next = HELD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cand_reg  <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            down_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            down_reg  <= down_next;
        end
    end

    assign kp.key_data  = data_reg;
    assign kp.key_valid = valid_reg;
    assign kp.key_down  = down_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: key-matrix model, history-based debounce reference,
// per-cycle output checks plus directed scenario checks and random episodes.
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int SCAN_DIV   = 4;
    localparam int DF         = 4;
    localparam int FRAME_CLKS = 3 * SCAN_DIV;
    localparam logic [3:0] CODE_TBL [12] = '{4'h1, 4'h2, 4'h3,
                                             4'h4, 4'h5, 4'h6,
                                             4'h7, 4'h8, 4'h9,
                                             4'hA, 4'hB, 4'hC};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] keys = '0;

    keypad_scan_if kp();

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Pressed key (r,c) connects column c to row r.
    for (genvar gi = 0; gi < 4; gi++) begin : g_matrix
        assign kp.key_row[gi] = |(keys[gi*3 +: 3] & kp.key_col);
    end

    // Reference: frame code 0 = nothing, -1 = several keys, else key code.
    function automatic int classify(input logic [11:0] f);
        int n;
        n = $countones(f);
        if (n == 0) return 0;
        if (n > 1) return -1;
        for (int i = 0; i < 12; i++) begin
            if (f[i]) return int'(CODE_TBL[i]);
        end
        return 0;
    endfunction

    int unsigned cyc;
    int          mcol;
    logic [11:0] mframe;
    int          hist[$];
    bit          mheld;
    bit          pend_v;
    int          pend_code;
    logic [3:0]  exp_data;
    logic        exp_valid;
    logic        exp_down;

    // Press accepted when the last DF frames are one identical key while not held;
    // release when the last DF frames are empty while held.
    always @(posedge clk) begin
        bit same;
        if (rst) begin
            cyc = 0; mcol = 0; mframe = '0; hist.delete(); mheld = 0; pend_v = 0;
            exp_valid = 1'b0; exp_data = 4'h0; exp_down = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (pend_v) begin
                pend_v = 0;
                hist.push_back(pend_code);
                if (hist.size() > DF) void'(hist.pop_front());
                if (hist.size() == DF) begin
                    same = 1;
                    foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
                    if (same && !mheld && hist[0] > 0) begin
                        mheld = 1;
                        exp_down = 1'b1;
                        if (kp.key_en) begin
                            exp_valid = 1'b1;
                            exp_data  = 4'(hist[0]);
                        end
                    end else if (same && mheld && hist[0] == 0) begin
                        mheld = 0;
                        exp_down = 1'b0;
                    end
                end
            end
            cyc++;
            if (cyc % SCAN_DIV == 0) begin
                for (int r = 0; r < 4; r++) mframe[r*3 + mcol] = keys[r*3 + mcol];
                if (mcol == 2) begin
                    pend_code = classify(mframe);
                    pend_v    = 1;
                    mframe    = '0;
                end
                mcol = (mcol + 1) % 3;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("key_col",   8'(kp.key_col),   8'(3'b001 << mcol));
        check("key_valid", 8'(kp.key_valid), 8'(exp_valid));
        check("key_data",  8'(kp.key_data),  8'(exp_data));
        check("key_down",  8'(kp.key_down),  8'(exp_down));
        if (kp.key_valid === 1'b1) pulses++;
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME_CLKS) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    int p0;
    int hold;

    initial begin
        kp.key_en = 1'b1;
        do_reset();
        check("rst_col",   8'(kp.key_col),   8'h01);
        check("rst_data",  8'(kp.key_data),  8'h00);
        check("rst_valid", 8'(kp.key_valid), 8'h00);
        check("rst_down",  8'(kp.key_down),  8'h00);
        repeat (SCAN_DIV) step();
        check("col_adv1", 8'(kp.key_col), 8'h02);
        repeat (SCAN_DIV) step();
        check("col_adv2", 8'(kp.key_col), 8'h04);
        repeat (SCAN_DIV) step();
        check("col_wrap", 8'(kp.key_col), 8'h01);

        // Key 5 held 8 frames, then released
        p0 = pulses; keys = 12'(1 << 4);
        frames(8);
        check("k5_pulses", 8'(pulses - p0), 8'd1);
        check("k5_data",   8'(kp.key_data), 8'h5);
        check("k5_down",   8'(kp.key_down), 8'h1);
        keys = '0;
        frames(3);
        check("k5_down_3none", 8'(kp.key_down), 8'h1);
        frames(2);
        check("k5_released", 8'(kp.key_down), 8'h0);

        // Key 9 bouncing every frame, then stable
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 12'(1 << 8) : 12'h000;
            frames(1);
        end
        check("bounce_none", 8'(pulses - p0), 8'd0);
        keys = 12'(1 << 8);
        frames(4);
        check("bounce_pre", 8'(pulses - p0), 8'd0);
        frames(1);
        check("bounce_pulse", 8'(pulses - p0), 8'd1);
        check("bounce_data",  8'(kp.key_data), 8'h9);
        keys = '0;
        frames(5);

        // Keys 1 and 3 together, then 1 alone
        p0 = pulses; keys = 12'b0000_0000_0101;
        frames(8);
        check("multi_pulses", 8'(pulses - p0), 8'd0);
        check("multi_down",   8'(kp.key_down), 8'h0);
        keys = 12'b0000_0000_0001;
        frames(5);
        check("multi_k1_pulse", 8'(pulses - p0), 8'd1);
        check("multi_k1_data",  8'(kp.key_data), 8'h1);
        keys = '0;
        frames(5);

        // '#' accepted with key_en low, then reported only after a fresh press
        p0 = pulses; kp.key_en = 1'b0; keys = 12'(1 << 11);
        frames(6);
        check("en0_pulses", 8'(pulses - p0), 8'd0);
        check("en0_data",   8'(kp.key_data), 8'h1);
        check("en0_down",   8'(kp.key_down), 8'h1);
        kp.key_en = 1'b1;
        frames(3);
        check("en1_held_pulses", 8'(pulses - p0), 8'd0);
        keys = '0;
        frames(5);
        check("en_release_down", 8'(kp.key_down), 8'h0);
        keys = 12'(1 << 11);
        frames(5);
        check("hash_pulse", 8'(pulses - p0), 8'd1);
        check("hash_data",  8'(kp.key_data), 8'hC);
        keys = '0;
        frames(5);

        // Reset while key 7 is held
        keys = 12'(1 << 6);
        frames(6);
        check("k7_data", 8'(kp.key_data), 8'h7);
        check("k7_down", 8'(kp.key_down), 8'h1);
        rst = 1'b1;
        step();
        check("midrst_data",  8'(kp.key_data),  8'h0);
        check("midrst_down",  8'(kp.key_down),  8'h0);
        check("midrst_valid", 8'(kp.key_valid), 8'h0);
        check("midrst_col",   8'(kp.key_col),   8'h01);
        step(); step();
        rst = 1'b0;
        p0 = pulses;
        frames(4);
        check("k7_repress_pre", 8'(pulses - p0), 8'd0);
        frames(1);
        check("k7_repress_pulse", 8'(pulses - p0), 8'd1);
        check("k7_repress_data",  8'(kp.key_data), 8'h7);
        keys = '0;
        frames(5);

        // Random episodes, including unaligned edges, second keys and key_en changes
        for (int ep = 0; ep < 16; ep++) begin
            keys = 12'(1 << $urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) keys = keys | 12'(1 << $urandom_range(0, 11));
            kp.key_en = ($urandom_range(0, 3) != 0);
            hold = $urandom_range(1, 7);
            repeat (hold * FRAME_CLKS + $urandom_range(0, FRAME_CLKS - 1)) step();
            keys = '0;
            repeat ($urandom_range(1, 6) * FRAME_CLKS + $urandom_range(0, 3)) step();
        end
        frames(5);
        check("final_down", 8'(kp.key_down), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
